// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned MinNumReq = 2;
  localparam int unsigned MaxNumReq = 8;
  localparam int unsigned MaxIdxW   = $clog2(MaxNumReq);

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester at or after start_i
// (wrapping modulo NumReq) that is requesting and not excluded.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   start_i,
  input  logic [NumReq-1:0] excl_i,
  output logic              found_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [NumReq-1:0] elig;

  assign elig = req_i & ~excl_i;

  // Scan candidates in circular order; start_i is always below NumReq, so a
  // single subtraction wraps and no index >= NumReq is ever produced.
  always_comb begin
    logic [IdxW:0] cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = {1'b0, start_i} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      if (!found_o && elig[cand[IdxW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-locked round-robin arbiter feeding a single FIFO write port.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned Width  = 8,
  localparam int unsigned IdxW  = idx_width(NumReq)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  input  logic [NumReq-1:0]              req_last_i,
  input  logic [NumReq-1:0][Width-1:0]   req_data_i,
  output logic [NumReq-1:0]              req_ready_o,
  output logic                           fifo_write_req_o,
  input  logic                           fifo_write_valid_i,
  output logic [Width-1:0]               fifo_data_o,
  output logic [IdxW-1:0]                grant_idx_o,
  output logic                           busy_o
);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;

  logic              owner_valid;
  logic              owner_last;
  logic [Width-1:0]  owner_data;
  logic [NumReq-1:0] owner_onehot;
  logic [IdxW-1:0]   owner_inc;

  logic [IdxW-1:0]   pick_start;
  logic [NumReq-1:0] pick_excl;
  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;

  // Owner datapath mux.
  assign owner_valid  = req_valid_i[owner_q];
  assign owner_last   = req_last_i[owner_q];
  assign owner_data   = req_data_i[owner_q];
  assign owner_onehot = NumReq'(1) << owner_q;
  assign owner_inc    = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);

  // While locked, look ahead past the owner so a last beat hands over with no
  // idle cycle; while idle, search from the stored pointer.
  assign pick_start = (state_q == ARB_LOCKED) ? owner_inc : rr_ptr_q;
  assign pick_excl  = (state_q == ARB_LOCKED) ? owner_onehot : '0;

  rr_picker #(
    .NumReq (NumReq)
  ) u_picker (
    .req_i   (req_valid_i),
    .start_i (pick_start),
    .excl_i  (pick_excl),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Next-state and output decode.
  always_comb begin
    logic xfer;
    state_d          = state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    fifo_write_req_o = 1'b0;
    fifo_data_o      = '0;
    req_ready_o      = '0;
    grant_idx_o      = '0;
    busy_o           = 1'b0;
    xfer             = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_LOCKED;
          owner_d = pick_idx;
        end
      end
      ARB_LOCKED: begin
        busy_o           = 1'b1;
        grant_idx_o      = owner_q;
        fifo_write_req_o = owner_valid;
        fifo_data_o      = owner_data;
        xfer             = owner_valid && fifo_write_valid_i;
        if (xfer) begin
          req_ready_o = owner_onehot;
          if (owner_last) begin
            rr_ptr_d = owner_inc;
            if (pick_found) begin
              owner_d = pick_idx;
            end else begin
              state_d = ARB_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: a 4x8 instance for directed scenarios and a
// 3x16 instance for the fairness run, both checked against a packet-level model.
module tb_fifo_write_arbiter;

  localparam int unsigned NA = 4;
  localparam int unsigned WA = 8;
  localparam int unsigned NB = 3;
  localparam int unsigned WB = 16;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [NA-1:0]         a_valid, a_last, a_ready;
  logic [NA-1:0][WA-1:0] a_data;
  logic                  a_wreq, a_busy;
  logic [WA-1:0]         a_fdata;
  logic [1:0]            a_grant;

  logic [NB-1:0]         b_valid, b_last, b_ready;
  logic [NB-1:0][WB-1:0] b_data;
  logic                  b_wreq, b_busy;
  logic [WB-1:0]         b_fdata;
  logic [1:0]            b_grant;

  logic fok [2];

  // Per-source packet generators: remaining packets, current length, beat, data sequence.
  int src_left [2][8];
  int src_len  [2][8];
  int src_beat [2][8];
  int src_seq  [2][8];
  bit src_hold [2][8];
  bit cons     [2][8];
  bit rand_len [2];

  // Packet-level model: is a packet locked, whose, and where the next search starts.
  bit m_locked [2];
  int m_owner  [2];
  int m_ptr    [2];

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt  [2];
  int pkt_cnt [2][8];
  int grant_log [$];

  fifo_write_arbiter #(.NumReq(NA), .Width(WA)) u_dut_a (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .req_valid_i        (a_valid),
    .req_last_i         (a_last),
    .req_data_i         (a_data),
    .req_ready_o        (a_ready),
    .fifo_write_req_o   (a_wreq),
    .fifo_write_valid_i (fok[0]),
    .fifo_data_o        (a_fdata),
    .grant_idx_o        (a_grant),
    .busy_o             (a_busy)
  );

  fifo_write_arbiter #(.NumReq(NB), .Width(WB)) u_dut_b (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .req_valid_i        (b_valid),
    .req_last_i         (b_last),
    .req_data_i         (b_data),
    .req_ready_o        (b_ready),
    .fifo_write_req_o   (b_wreq),
    .fifo_write_valid_i (fok[1]),
    .fifo_data_o        (b_fdata),
    .grant_idx_o        (b_grant),
    .busy_o             (b_busy)
  );

  // Drive requester pins from the generator state.
  always_comb begin
    for (int i = 0; i < NA; i++) begin
      a_valid[i] = (src_left[0][i] > 0) && !src_hold[0][i];
      a_last[i]  = (src_beat[0][i] == src_len[0][i] - 1);
      a_data[i]  = WA'(i * 64 + src_seq[0][i] % 64);
    end
    for (int i = 0; i < NB; i++) begin
      b_valid[i] = (src_left[1][i] > 0) && !src_hold[1][i];
      b_last[i]  = (src_beat[1][i] == src_len[1][i] - 1);
      b_data[i]  = WB'(i * 4096 + src_seq[1][i] % 4096);
    end
  end

  function automatic bit src_valid(input int s, input int i);
    return (src_left[s][i] > 0) && !src_hold[s][i];
  endfunction

  function automatic bit src_last(input int s, input int i);
    return src_beat[s][i] == src_len[s][i] - 1;
  endfunction

  function automatic longint src_data(input int s, input int i);
    return (s == 0) ? longint'(i * 64 + src_seq[0][i] % 64) : longint'(i * 4096 + src_seq[1][i] % 4096);
  endfunction

  function automatic longint out_busy(input int s);
    return (s == 0) ? longint'(a_busy) : longint'(b_busy);
  endfunction
  function automatic longint out_wreq(input int s);
    return (s == 0) ? longint'(a_wreq) : longint'(b_wreq);
  endfunction
  function automatic longint out_data(input int s);
    return (s == 0) ? longint'(a_fdata) : longint'(b_fdata);
  endfunction
  function automatic longint out_grant(input int s);
    return (s == 0) ? longint'(a_grant) : longint'(b_grant);
  endfunction
  function automatic longint out_ready(input int s);
    return (s == 0) ? longint'(a_ready) : longint'(b_ready);
  endfunction

  // First valid requester in circular order from start, skipping excl; -1 if none.
  function automatic int pick(input int s, input int start, input int excl);
    int n;
    n = (s == 0) ? NA : NB;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (start + k) % n;
      if (c != excl && src_valid(s, c)) return c;
    end
    return -1;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Compare one instance against the model, then advance the model past the next edge.
  task automatic observe(input int s);
    int    n, ow, w;
    bit    xfer;
    string pre;
    pre = (s == 0) ? "a" : "b";
    n   = (s == 0) ? NA : NB;
    for (int i = 0; i < 8; i++) cons[s][i] = 1'b0;
    if (!rst_ni) begin
      m_locked[s] = 1'b0;
      m_owner[s]  = 0;
      m_ptr[s]    = 0;
    end
    ow   = m_owner[s];
    xfer = m_locked[s] && src_valid(s, ow) && fok[s];
    check({pre, ".busy"},  out_busy(s),  longint'(m_locked[s]));
    check({pre, ".grant"}, out_grant(s), m_locked[s] ? longint'(ow) : 0);
    check({pre, ".wreq"},  out_wreq(s),  longint'(m_locked[s] && src_valid(s, ow)));
    check({pre, ".data"},  out_data(s),  m_locked[s] ? src_data(s, ow) : 0);
    check({pre, ".ready"}, out_ready(s), xfer ? (longint'(1) << ow) : 0);
    if (!rst_ni) return;
    if (xfer) begin
      wr_cnt[s]++;
      cons[s][ow] = 1'b1;
      if (src_last(s, ow)) begin
        pkt_cnt[s][ow]++;
        if (s == 0) grant_log.push_back(int'(out_grant(s)));
      end
    end
    if (!m_locked[s]) begin
      w = pick(s, m_ptr[s], -1);
      if (w >= 0) begin
        m_locked[s] = 1'b1;
        m_owner[s]  = w;
      end
    end else if (xfer && src_last(s, ow)) begin
      m_ptr[s] = (ow + 1) % n;
      w = pick(s, m_ptr[s], ow);
      if (w >= 0) m_owner[s] = w;
      else        m_locked[s] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    observe(0);
    observe(1);
  end

  // Retire consumed beats shortly after the edge that took them.
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        if (cons[s][i]) begin
          cons[s][i] = 1'b0;
          src_seq[s][i]++;
          if (src_beat[s][i] == src_len[s][i] - 1) begin
            src_beat[s][i] = 0;
            src_left[s][i]--;
            if (rand_len[s]) src_len[s][i] = int'($urandom_range(5, 1));
          end else begin
            src_beat[s][i]++;
          end
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_src();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        src_left[s][i] = 0;
        src_len[s][i]  = 1;
        src_beat[s][i] = 0;
        src_seq[s][i]  = 0;
        src_hold[s][i] = 1'b0;
      end
      rand_len[s] = 1'b0;
      fok[s]      = 1'b1;
    end
  endtask

  task automatic do_reset();
    next_cyc();
    rst_ni = 1'b0;
    clear_src();
    next_cyc();
    next_cyc();
    rst_ni = 1'b1;
  endtask

  task automatic add_pkt(input int s, input int i, input int count, input int len);
    src_left[s][i] = count;
    src_len[s][i]  = len;
    src_beat[s][i] = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, mn, mx, tot;
    clear_src();

    // Idle after reset, then a single-beat packet from requester 2.
    do_reset();
    mid();
    check("t1 idle busy", a_busy, 0);
    check("t1 idle wreq", a_wreq, 0);
    check("t1 idle data", a_fdata, 0);
    check("t1 idle grant", a_grant, 0);
    next_cyc(); add_pkt(0, 2, 1, 1); mid();
    check("t1 c0 busy", a_busy, 0);
    check("t1 c0 ready", a_ready, 0);
    next_cyc(); mid();
    check("t1 c1 busy", a_busy, 1);
    check("t1 c1 grant", a_grant, 2);
    check("t1 c1 wreq", a_wreq, 1);
    check("t1 c1 data", a_fdata, 8'h80);
    check("t1 c1 ready", a_ready, 4'b0100);
    next_cyc(); mid();
    check("t1 c2 busy", a_busy, 0);

    // All four requesters, two 2-beat packets each, FIFO always ready.
    do_reset();
    next_cyc();
    grant_log.delete();
    base = wr_cnt[0];
    for (int i = 0; i < 4; i++) add_pkt(0, i, 2, 2);
    next_cyc(); mid();
    check("t2 c1 grant", a_grant, 0);
    repeat (7) next_cyc();
    mid();
    check("t2 writes by c8", wr_cnt[0] - base, 8);
    repeat (8) next_cyc();
    mid();
    check("t2 writes by c16", wr_cnt[0] - base, 16);
    next_cyc(); mid();
    check("t2 c17 busy", a_busy, 0);
    check("t2 packets", grant_log.size(), 8);
    if (grant_log.size() >= 5) begin
      check("t2 order0", grant_log[0], 0);
      check("t2 order1", grant_log[1], 1);
      check("t2 order2", grant_log[2], 2);
      check("t2 order3", grant_log[3], 3);
      check("t2 order4", grant_log[4], 0);
    end

    // FIFO full for three cycles during requester 1's packet.
    do_reset();
    next_cyc(); base = wr_cnt[0]; add_pkt(0, 1, 1, 4);
    next_cyc();
    next_cyc();
    next_cyc(); fok[0] = 1'b0;
    next_cyc(); mid();
    check("t3 stall wreq", a_wreq, 1);
    check("t3 stall ready", a_ready, 0);
    check("t3 stall data", a_fdata, 8'h42);
    check("t3 stall grant", a_grant, 1);
    check("t3 stall writes", wr_cnt[0] - base, 2);
    next_cyc();
    next_cyc(); fok[0] = 1'b1; mid();
    check("t3 resume ready", a_ready, 4'b0010);
    check("t3 resume data", a_fdata, 8'h42);
    next_cyc(); mid();
    check("t3 last data", a_fdata, 8'h43);
    next_cyc(); mid();
    check("t3 done busy", a_busy, 0);
    check("t3 writes", wr_cnt[0] - base, 4);

    // Owner 3 pauses mid-packet while requester 0 waits.
    do_reset();
    next_cyc(); add_pkt(0, 3, 1, 3);
    next_cyc(); add_pkt(0, 0, 1, 1); mid();
    check("t4 c1 grant", a_grant, 3);
    check("t4 c1 data", a_fdata, 8'hC0);
    next_cyc(); src_hold[0][3] = 1'b1; mid();
    check("t4 bubble grant", a_grant, 3);
    check("t4 bubble wreq", a_wreq, 0);
    check("t4 bubble ready", a_ready, 0);
    next_cyc(); mid();
    check("t4 bubble2 grant", a_grant, 3);
    next_cyc(); src_hold[0][3] = 1'b0; mid();
    check("t4 c4 ready", a_ready, 4'b1000);
    check("t4 c4 data", a_fdata, 8'hC1);
    next_cyc(); mid();
    check("t4 c5 data", a_fdata, 8'hC2);
    next_cyc(); mid();
    check("t4 c6 grant", a_grant, 0);
    check("t4 c6 ready", a_ready, 4'b0001);

    // Reset during the second beat of a 4-beat packet.
    do_reset();
    next_cyc(); add_pkt(0, 1, 1, 4);
    next_cyc();
    next_cyc();
    rst_ni = 1'b0;
    #1;
    check("t5 rst busy", a_busy, 0);
    check("t5 rst wreq", a_wreq, 0);
    check("t5 rst ready", a_ready, 0);
    check("t5 rst data", a_fdata, 0);
    check("t5 rst grant", a_grant, 0);
    clear_src();
    next_cyc();
    next_cyc();
    rst_ni = 1'b1;
    add_pkt(0, 0, 1, 1);
    mid();
    check("t5 r0 busy", a_busy, 0);
    next_cyc(); mid();
    check("t5 r1 busy", a_busy, 1);
    check("t5 r1 grant", a_grant, 0);
    check("t5 r1 ready", a_ready, 4'b0001);

    // Fairness on the 3-requester instance with random packet lengths.
    do_reset();
    next_cyc();
    rand_len[1] = 1'b1;
    for (int i = 0; i < NB; i++) begin
      pkt_cnt[1][i] = 0;
      add_pkt(1, i, 1000000, int'($urandom_range(5, 1)));
    end
    repeat (1000) next_cyc();
    for (int i = 0; i < NB; i++) src_left[1][i] = 0;
    mn = pkt_cnt[1][0];
    mx = pkt_cnt[1][0];
    tot = 0;
    for (int i = 0; i < NB; i++) begin
      if (pkt_cnt[1][i] < mn) mn = pkt_cnt[1][i];
      if (pkt_cnt[1][i] > mx) mx = pkt_cnt[1][i];
      tot += pkt_cnt[1][i];
    end
    check("t6 spread within 1", longint'(mx - mn <= 1), 1);
    check("t6 enough packets", longint'(tot >= 150), 1);

    repeat (2) next_cyc();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
